// File: rtl/buffer_in_selector_if.sv
// Handshake bundle between the sample sources, the selector and the buffer write port.
// The slave view belongs to the selector; the master view drives sources and the buffer side.
interface buffer_in_selector_if #(
  parameter int unsigned DATA_WIDTH = 11,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned SEL_WIDTH  = 1
);
  logic [NUM_SRC*DATA_WIDTH-1:0] data_in;
  logic [NUM_SRC-1:0]            valid_in;
  logic [NUM_SRC-1:0]            ready_in;
  logic [DATA_WIDTH-1:0]         data_out;
  logic                          valid_out;
  logic                          ready_out;
  logic [SEL_WIDTH-1:0]          src_out;

  modport slave (
    input  data_in, valid_in, ready_out,
    output ready_in, data_out, valid_out, src_out
  );

  modport master (
    output data_in, valid_in, ready_out,
    input  ready_in, data_out, valid_out, src_out
  );
endinterface

// File: rtl/buffer_in_selector.sv
// Selects one of NUM_SRC signed sample sources into a 2-entry output queue, with manual
// selection or automatic burst rotation across sources.
module buffer_in_selector #(
  parameter int unsigned DATA_WIDTH = 11,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned SEL_WIDTH  = 1,
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned CNT_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  buffer_in_selector_if.slave  bus,
  input  logic                 mode,
  input  logic [SEL_WIDTH-1:0] select,
  output logic                 burst_done
);

  localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(BURST_LEN - 1);
  localparam logic [SEL_WIDTH-1:0] SrcLast = SEL_WIDTH'(NUM_SRC - 1);

  logic [DATA_WIDTH-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic [SEL_WIDTH-1:0]  head_src_q, head_src_d, tail_src_q, tail_src_d;
  logic [1:0]            occ_q, occ_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [SEL_WIDTH-1:0]  cur_q, cur_d;
  logic                  mode_q;
  logic                  bd_q, bd_d;

  logic                  auto_active, mode_enter;
  logic [SEL_WIDTH-1:0]  cur;
  logic                  cur_ok, sel_ok, can_push, push, pop;
  logic [NUM_SRC-1:0]    ready_in;
  logic [DATA_WIDTH-1:0] push_data;

  // The MODE 0->1 cycle still serves the manual source; auto takes over after the reload.
  assign auto_active = mode & mode_q;
  assign mode_enter  = mode & ~mode_q;
  assign cur         = auto_active ? cur_q : select;
  assign cur_ok      = 32'(cur) < NUM_SRC;
  assign sel_ok      = 32'(select) < NUM_SRC;
  // Full queue refuses a push even when popping, so ready_out never reaches ready_in.
  assign can_push    = (occ_q != 2'd2) && cur_ok && !rst;
  assign pop         = (occ_q != 2'd0) && bus.ready_out;

  always_comb begin
    ready_in  = '0;
    push_data = '0;
    push      = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cur == SEL_WIDTH'(i)) begin
        ready_in[i] = can_push;
        push_data   = bus.data_in[i*DATA_WIDTH +: DATA_WIDTH];
        push        = can_push & bus.valid_in[i];
      end
    end
  end

  always_comb begin
    head_data_d = head_data_q;
    head_src_d  = head_src_q;
    tail_data_d = tail_data_q;
    tail_src_d  = tail_src_q;
    occ_d       = occ_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) begin
          head_data_d = push_data;
          head_src_d  = cur;
        end else begin
          tail_data_d = push_data;
          tail_src_d  = cur;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_data_d = tail_data_q;
        head_src_d  = tail_src_q;
        occ_d       = occ_q - 2'd1;
      end
      // Push and pop together only happens at occupancy 1: new word replaces the head.
      2'b11: begin
        head_data_d = push_data;
        head_src_d  = cur;
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    cur_d = cur_q;
    bd_d  = 1'b0;
    if (mode_enter) begin
      cnt_d = '0;
      cur_d = sel_ok ? select : '0;
    end else if (auto_active && push) begin
      if (cnt_q == CntLast) begin
        cnt_d = '0;
        cur_d = (cur_q == SrcLast) ? '0 : cur_q + SEL_WIDTH'(1);
        bd_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_data_q <= '0;
      head_src_q  <= '0;
      tail_data_q <= '0;
      tail_src_q  <= '0;
      occ_q       <= '0;
      cnt_q       <= '0;
      cur_q       <= '0;
      mode_q      <= 1'b0;
      bd_q        <= 1'b0;
    end else begin
      head_data_q <= head_data_d;
      head_src_q  <= head_src_d;
      tail_data_q <= tail_data_d;
      tail_src_q  <= tail_src_d;
      occ_q       <= occ_d;
      cnt_q       <= cnt_d;
      cur_q       <= cur_d;
      mode_q      <= mode;
      bd_q        <= bd_d;
    end
  end

  assign bus.ready_in  = ready_in;
  assign bus.data_out  = head_data_q;
  assign bus.src_out   = head_src_q;
  assign bus.valid_out = (occ_q != 2'd0);
  assign burst_done    = bd_q;

endmodule

// File: tb/tb_buffer_in_selector.sv
// Directed bench for buffer_in_selector with three sources and a burst length of four.
module tb_buffer_in_selector;
  localparam int unsigned DW = 11;
  localparam int unsigned NS = 3;
  localparam int unsigned SW = 2;
  localparam int unsigned BL = 4;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode;
  logic [SW-1:0] select;
  logic          burst_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  buffer_in_selector_if #(.DATA_WIDTH(DW), .NUM_SRC(NS), .SEL_WIDTH(SW)) bus ();

  buffer_in_selector #(
    .DATA_WIDTH(DW),
    .NUM_SRC   (NS),
    .SEL_WIDTH (SW),
    .BURST_LEN (BL),
    .CNT_WIDTH (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mode      (mode),
    .select    (select),
    .burst_done(burst_done)
  );

  typedef struct {
    logic       mode;
    int         sel;
    logic [2:0] vin;
    int         d0, d1, d2;
    logic       rout;
    logic [2:0] e_rin;
    logic       e_vout;
    int         e_dout;
    int         e_src;
    logic       e_bd;
  } vec_t;

  function automatic logic [31:0] w(input int v);
    logic [DW-1:0] t;
    t = DW'(v);
    return {{(32-DW){1'b0}}, t};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_data(input int d0, input int d1, input int d2);
    bus.data_in = {DW'(d2), DW'(d1), DW'(d0)};
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [2:0] rin, input logic vout,
                           input int dout, input int src, input logic bd);
    chk({tag, " ready_in"}, {29'b0, bus.ready_in}, {29'b0, rin});
    chk({tag, " valid_out"}, {31'b0, bus.valid_out}, {31'b0, vout});
    chk({tag, " burst_done"}, {31'b0, burst_done}, {31'b0, bd});
    if (vout) begin
      chk({tag, " data_out"}, {{(32-DW){1'b0}}, bus.data_out}, w(dout));
      chk({tag, " src_out"}, {30'b0, bus.src_out}, 32'(src));
    end
  endtask

  task automatic run_row(input vec_t v, input int idx);
    mode         = v.mode;
    select       = SW'(v.sel);
    bus.valid_in = v.vin;
    bus.ready_out = v.rout;
    set_data(v.d0, v.d1, v.d2);
    #1;
    check_out($sformatf("row%0d", idx), v.e_rin, v.e_vout, v.e_dout, v.e_src, v.e_bd);
    cycle();
  endtask

  vec_t tbl[17];
  int   srcs[10];

  initial begin
    // Manual pass-through, backpressure, then invalid select after draining.
    tbl[0]  = '{1'b0, 1, 3'b011, 77, -1024, 0, 1'b1, 3'b010, 1'b0, 0, 0, 1'b0};
    tbl[1]  = '{1'b0, 1, 3'b011, 77, 1023, 0, 1'b1, 3'b010, 1'b1, -1024, 1, 1'b0};
    tbl[2]  = '{1'b0, 1, 3'b011, 77, 5, 0, 1'b1, 3'b010, 1'b1, 1023, 1, 1'b0};
    tbl[3]  = '{1'b0, 1, 3'b000, 0, 0, 0, 1'b1, 3'b010, 1'b1, 5, 1, 1'b0};
    tbl[4]  = '{1'b0, 1, 3'b000, 0, 0, 0, 1'b1, 3'b010, 1'b0, 0, 0, 1'b0};
    tbl[5]  = '{1'b0, 0, 3'b001, 10, 0, 0, 1'b0, 3'b001, 1'b0, 0, 0, 1'b0};
    tbl[6]  = '{1'b0, 0, 3'b001, 11, 0, 0, 1'b0, 3'b001, 1'b1, 10, 0, 1'b0};
    tbl[7]  = '{1'b0, 0, 3'b001, 12, 0, 0, 1'b0, 3'b000, 1'b1, 10, 0, 1'b0};
    tbl[8]  = '{1'b0, 0, 3'b001, 12, 0, 0, 1'b0, 3'b000, 1'b1, 10, 0, 1'b0};
    tbl[9]  = '{1'b0, 0, 3'b001, 12, 0, 0, 1'b1, 3'b000, 1'b1, 10, 0, 1'b0};
    tbl[10] = '{1'b0, 0, 3'b001, 12, 0, 0, 1'b1, 3'b001, 1'b1, 11, 0, 1'b0};
    tbl[11] = '{1'b0, 0, 3'b000, 0, 0, 0, 1'b1, 3'b001, 1'b1, 12, 0, 1'b0};
    tbl[12] = '{1'b0, 0, 3'b000, 0, 0, 0, 1'b1, 3'b001, 1'b0, 0, 0, 1'b0};
    tbl[13] = '{1'b0, 2, 3'b100, 0, 0, 300, 1'b0, 3'b100, 1'b0, 0, 0, 1'b0};
    tbl[14] = '{1'b0, 3, 3'b111, 1, 2, 3, 1'b1, 3'b000, 1'b1, 300, 2, 1'b0};
    tbl[15] = '{1'b0, 3, 3'b111, 1, 2, 3, 1'b1, 3'b000, 1'b0, 0, 0, 1'b0};
    tbl[16] = '{1'b0, 3, 3'b111, 1, 2, 3, 1'b1, 3'b000, 1'b0, 0, 0, 1'b0};
    srcs = '{1, 1, 1, 2, 2, 2, 2, 2, 0, 0};

    rst           = 1'b1;
    mode          = 1'b0;
    select        = '0;
    bus.valid_in  = '0;
    bus.ready_out = 1'b0;
    set_data(0, 0, 0);
    #1;
    check_out("reset", 3'b000, 1'b0, 0, 0, 1'b0);
    chk("reset data_out", {{(32-DW){1'b0}}, bus.data_out}, 32'd0);
    chk("reset src_out", {30'b0, bus.src_out}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("release ready_in", {29'b0, bus.ready_in}, 32'b001);
    cycle();

    for (int r = 0; r < 17; r++) run_row(tbl[r], r);

    // Enter auto mode with no push in the transition cycle; bursts start at source 0.
    mode          = 1'b1;
    select        = '0;
    bus.valid_in  = '0;
    bus.ready_out = 1'b1;
    #1;
    check_out("auto_enter", 3'b001, 1'b0, 0, 0, 1'b0);
    cycle();
    for (int k = 0; k < 15; k++) begin
      int s, sp;
      s  = (k / 4) % 3;
      sp = ((k - 1) / 4) % 3;
      bus.valid_in = (k < 14) ? 3'b111 : 3'b000;
      set_data(k, 100 + k, 200 + k);
      #1;
      check_out($sformatf("auto%0d", k), 3'(1 << s), k > 0, sp * 100 + k - 1, sp,
                (k > 0) && ((k - 1) % 4 == 3));
      cycle();
    end

    // Three manual pushes, then MODE 0->1 with SELECT=2 pushing in the transition cycle.
    for (int j = 0; j < 10; j++) begin
      int sp;
      sp = (j > 0) ? srcs[j - 1] : 0;
      mode         = (j >= 3);
      select       = (j < 3) ? SW'(1) : SW'(2);
      bus.valid_in = 3'b111;
      set_data(50 + j, 150 + j, 250 + j);
      #1;
      check_out($sformatf("switch%0d", j), 3'(1 << srcs[j]), j > 0, sp * 100 + 50 + j - 1, sp,
                j == 8);
      cycle();
    end
    mode         = 1'b0;
    bus.valid_in = '0;
    cycle();

    // Mid-stream reset with two words queued.
    select        = '0;
    bus.ready_out = 1'b0;
    bus.valid_in  = 3'b001;
    set_data(40, 0, 0);
    cycle();
    set_data(41, 0, 0);
    cycle();
    chk("prereset valid_out", {31'b0, bus.valid_out}, 32'd1);
    chk("prereset ready_in", {29'b0, bus.ready_in}, 32'b000);
    #2;
    rst = 1'b1;
    #1;
    check_out("midreset", 3'b000, 1'b0, 0, 0, 1'b0);
    chk("midreset data_out", {{(32-DW){1'b0}}, bus.data_out}, 32'd0);
    chk("midreset src_out", {30'b0, bus.src_out}, 32'd0);
    @(negedge clk);
    rst          = 1'b0;
    bus.valid_in = '0;
    #1;
    check_out("postreset", 3'b001, 1'b0, 0, 0, 1'b0);
    cycle();
    chk("postreset valid_out", {31'b0, bus.valid_out}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
